// File: rtl/irq_event_ctrl.sv
// Interrupt event controller: sticky pending bits with per-source enables,
// a gap-enforcing active-low host interrupt and a small register port.
module irq_event_ctrl #(
  parameter int NUM_IRQ    = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] event_edge,
  input  logic [NUM_IRQ-1:0] event_level,
  output logic [NUM_IRQ-1:0] latch_enable,
  output logic [NUM_IRQ-1:0] latch_clear,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [NUM_IRQ-1:0] wr_data,
  input  logic [1:0]         rd_addr,
  output logic [NUM_IRQ-1:0] rd_data,
  output logic               irq_n
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               irq_n_reg, irq_n_next;
  logic [NUM_IRQ-1:0] ie_reg, ie_next;
  logic [NUM_IRQ-1:0] ip_reg, ip_next;
  logic [NUM_IRQ-1:0] latch_clear_reg;
  logic [NUM_IRQ-1:0] rd_data_reg, rd_mux;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic               active;

  // W1C bits drive both the pending clear and the latch clear strobe
  assign w1c_mask = (wr_en && (wr_addr == 2'd1)) ? wr_data : '0;
  assign ie_next  = (wr_en && (wr_addr == 2'd0)) ? wr_data : ie_reg;
  assign ip_next  = event_edge | (ip_reg & ~w1c_mask);
  assign active   = |(ip_reg & ie_reg);

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      2'd0:    rd_mux = ie_reg;
      2'd1:    rd_mux = ip_reg;
      2'd2:    rd_mux = ip_reg & ie_reg;
      2'd3:    rd_mux = event_level;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_reg          <= '0;
      ip_reg          <= '0;
      latch_clear_reg <= '1;
      rd_data_reg     <= '0;
    end else begin
      ie_reg          <= ie_next;
      ip_reg          <= ip_next;
      latch_clear_reg <= w1c_mask;
      rd_data_reg     <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      irq_n_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      irq_n_reg <= irq_n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (active) state_next = ASSERT;
      end
      ASSERT: begin
        if (!active) begin
          state_next = GAP;
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        // The gap always runs to completion; pending events wait for IDLE
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // irq_n is registered from the next state so it lines up with the state
  always_comb begin
    irq_n_next = (state_next != ASSERT);
  end

  assign latch_enable = ie_reg;
  assign latch_clear  = latch_clear_reg;
  assign rd_data      = rd_data_reg;
  assign irq_n        = irq_n_reg;

endmodule

// File: tb/tb_irq_event_ctrl.sv
// Scoreboard bench for irq_event_ctrl: a cycle-level reference model queues
// expected outputs, a separate monitor compares after each rising edge.
module tb_irq_event_ctrl;

  localparam int N   = 8;
  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] event_edge = '0;
  logic [N-1:0] event_level = '0;
  logic [N-1:0] latch_enable;
  logic [N-1:0] latch_clear;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_addr = '0;
  logic [N-1:0] wr_data = '0;
  logic [1:0]   rd_addr = '0;
  logic [N-1:0] rd_data;
  logic         irq_n;

  irq_event_ctrl #(.NUM_IRQ(N), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .event_edge   (event_edge),
    .event_level  (event_level),
    .latch_enable (latch_enable),
    .latch_clear  (latch_clear),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .irq_n        (irq_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] rd;
    logic [N-1:0] lc;
    logic [N-1:0] le;
    logic         irq_n;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: register contents plus the interrupt line history
  logic [N-1:0] m_ie, m_ip;
  logic         m_irq_low;
  int           m_high_run;

  task automatic model_reset();
    m_ie       = '0;
    m_ip       = '0;
    m_irq_low  = 1'b0;
    m_high_run = GAP + 1;
  endtask

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the edge
  task automatic apply(input logic [N-1:0] e, input logic [N-1:0] l, input logic we,
                       input logic [1:0] wa, input logic [N-1:0] wd, input logic [1:0] ra);
    exp_t         x;
    logic [N-1:0] w1c;
    logic         act;
    event_edge  = e;
    event_level = l;
    wr_en       = we;
    wr_addr     = wa;
    wr_data     = wd;
    rd_addr     = ra;
    w1c = (we && wa == 2'd1) ? wd : '0;
    case (ra)
      2'd0: x.rd = m_ie;
      2'd1: x.rd = m_ip;
      2'd2: x.rd = m_ip & m_ie;
      default: x.rd = l;
    endcase
    x.lc = w1c;
    act  = |(m_ip & m_ie);
    // Line goes low when something is active and it is either already low
    // or has been high for longer than the mandatory gap
    m_irq_low = act && (m_irq_low || m_high_run > GAP);
    m_high_run = m_irq_low ? 0 : ((m_high_run > GAP) ? GAP + 1 : m_high_run + 1);
    if (we && wa == 2'd0) m_ie = wd;
    m_ip = e | (m_ip & ~w1c);
    x.le    = m_ie;
    x.irq_n = ~m_irq_low;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic [N-1:0] e, input logic we, input logic [1:0] wa,
                     input logic [N-1:0] wd, input logic [1:0] ra);
    @(negedge clk);
    apply(e, N'($urandom), we, wa, wd, ra);
  endtask

  task automatic idle(input int n, input logic [1:0] ra);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 2'd0, '0, ra);
  endtask

  task automatic check_reset_outputs();
    check("rst_irq_n", N'(irq_n), N'(1));
    check("rst_rd_data", rd_data, '0);
    check("rst_latch_clear", latch_clear, '1);
    check("rst_latch_enable", latch_enable, '0);
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("rd_data", rd_data, x.rd);
        check("latch_clear", latch_clear, x.lc);
        check("latch_enable", latch_enable, x.le);
        check("irq_n", N'(irq_n), N'(x.irq_n));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    apply('0, '0, 1'b0, 2'd0, '0, 2'd0);
    idle(2, 2'd1);

    // Enabled source: pending then interrupt, IA readback
    cyc('0, 1'b1, 2'd0, 8'h01, 2'd0);
    cyc(8'h01, 1'b0, 2'd0, '0, 2'd1);
    idle(3, 2'd2);
    // W1C clears pending, strobes latch_clear, opens the gap
    cyc('0, 1'b1, 2'd1, 8'h01, 2'd1);
    idle(8, 2'd1);
    // Set wins over a same-cycle W1C but latch_clear still fires
    cyc(8'h02, 1'b0, 2'd0, '0, 2'd1);
    cyc(8'h02, 1'b1, 2'd1, 8'h02, 2'd1);
    idle(2, 2'd1);
    cyc('0, 1'b1, 2'd1, 8'h02, 2'd1);
    idle(8, 2'd1);
    // Event during the gap waits for the full gap plus one idle cycle
    cyc('0, 1'b1, 2'd0, 8'h03, 2'd0);
    cyc(8'h01, 1'b0, 2'd0, '0, 2'd2);
    idle(3, 2'd2);
    cyc('0, 1'b1, 2'd1, 8'h01, 2'd1);
    idle(1, 2'd1);
    cyc(8'h02, 1'b0, 2'd0, '0, 2'd1);
    idle(10, 2'd2);
    // Pending while disabled, then enabling raises the line
    cyc('0, 1'b1, 2'd0, 8'h00, 2'd0);
    cyc('0, 1'b1, 2'd1, 8'hff, 2'd1);
    idle(6, 2'd1);
    cyc(8'h80, 1'b0, 2'd0, '0, 2'd1);
    idle(4, 2'd2);
    cyc('0, 1'b1, 2'd0, 8'h80, 2'd2);
    idle(4, 2'd2);
    // Writes to read-only addresses are ignored
    cyc('0, 1'b1, 2'd2, 8'h55, 2'd0);
    cyc('0, 1'b1, 2'd3, 8'haa, 2'd1);
    idle(2, 2'd0);

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2000; i++) begin
        logic [N-1:0] e;
        logic         we;
        e  = ($urandom_range(0, 5) == 0) ? N'($urandom) & N'($urandom) : '0;
        we = ($urandom_range(0, 3) == 0);
        cyc(e, we, 2'($urandom), N'($urandom), 2'($urandom));
      end
      // Asynchronous reset in the middle of traffic
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      apply('0, '0, 1'b0, 2'd0, '0, 2'd0);
    end

    idle(3, 2'd0);
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
